// File: rtl/fsm_ones_pkg.sv
// Shared state encodings and widths for the three-consecutive-ones detectors.
package fsm_ones_pkg;

  localparam int MEALY_STATE_W = 2;
  localparam int MOORE_STATE_W = 2;

  typedef enum logic [MEALY_STATE_W-1:0] {
    ML_S0 = 2'd0,
    ML_S1 = 2'd1,
    ML_S2 = 2'd2
  } mealy_state_t;

  typedef enum logic [MOORE_STATE_W-1:0] {
    MR_S0 = 2'd0,
    MR_S1 = 2'd1,
    MR_S2 = 2'd2,
    MR_S3 = 2'd3
  } moore_state_t;

  // Mealy next state is shared by both Mealy variants.
  function automatic mealy_state_t mealy_next(input mealy_state_t cur, input logic bit_in);
    mealy_state_t nxt;
    nxt = ML_S0;
    if (bit_in) begin
      case (cur)
        ML_S0:   nxt = ML_S1;
        ML_S1:   nxt = ML_S2;
        ML_S2:   nxt = ML_S2;
        default: nxt = ML_S0;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fsm_ones_mealy_1.sv
// Mealy detector with a purely combinational output (zero latency).
//   state | meaning
//   ML_S0 | no ones seen since last 0 / reset
//   ML_S1 | one 1 seen
//   ML_S2 | two or more 1s seen
module fsm_ones_mealy_1
  import fsm_ones_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic detect
);

  mealy_state_t state_q;
  mealy_state_t state_d;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ML_S0;
    else        state_q <= state_d;
  end

  // Output is gated by reset so nothing escapes while reset is held low.
  always_comb begin
    state_d = mealy_next(state_q, data_in);
    detect  = (state_q == ML_S2) && data_in && reset;
  end

endmodule

// File: rtl/fsm_ones_mealy_2.sv
// Mealy detector whose output is registered, giving one clock of latency.
//   state | meaning
//   ML_S0 | no ones seen since last 0 / reset
//   ML_S1 | one 1 seen
//   ML_S2 | two or more 1s seen
module fsm_ones_mealy_2
  import fsm_ones_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic detect
);

  mealy_state_t state_q;
  mealy_state_t state_d;
  logic         detect_d;
  logic         detect_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ML_S0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      detect_q <= detect_d;
    end
  end

  always_comb begin
    state_d  = mealy_next(state_q, data_in);
    detect_d = (state_q == ML_S2) && data_in;
  end

  assign detect = detect_q;

endmodule

// File: rtl/fsm_ones_moore_1.sv
// Moore detector: output decoded from the state register alone.
//   state | meaning
//   MR_S0 | no ones seen since last 0 / reset
//   MR_S1 | one 1 seen
//   MR_S2 | two 1s seen
//   MR_S3 | three or more 1s seen (detect)
module fsm_ones_moore_1
  import fsm_ones_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic detect
);

  moore_state_t state_q;
  moore_state_t state_d;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= MR_S0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = MR_S0;
    if (data_in) begin
      case (state_q)
        MR_S0:   state_d = MR_S1;
        MR_S1:   state_d = MR_S2;
        MR_S2:   state_d = MR_S3;
        MR_S3:   state_d = MR_S3;
        default: state_d = MR_S0;
      endcase
    end
    detect = (state_q == MR_S3);
  end

endmodule

// File: rtl/fsm_ones.sv
// Wrapper running the three ones-detector variants side by side on one input.
module fsm_ones
  import fsm_ones_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic detect_mealy_1,
  output logic detect_mealy_2,
  output logic detect_moore_1
);

  fsm_ones_mealy_1 u_mealy_1 (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .detect  (detect_mealy_1)
  );

  fsm_ones_mealy_2 u_mealy_2 (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .detect  (detect_mealy_2)
  );

  fsm_ones_moore_1 u_moore_1 (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .detect  (detect_moore_1)
  );

endmodule

// File: tb/tb_fsm_ones.sv
// Scoreboard bench for fsm_ones: a ones-run counter predicts every detect output.
module tb_fsm_ones;

  logic clk = 1'b0;
  logic reset;
  logic data_in;
  logic detect_mealy_1;
  logic detect_mealy_2;
  logic detect_moore_1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic exp_m1;
    logic exp_reg;
    logic obs_m1;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        ones_cnt = 0;

  always #5 clk = ~clk;

  fsm_ones dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .detect_mealy_1 (detect_mealy_1),
    .detect_mealy_2 (detect_mealy_2),
    .detect_moore_1 (detect_moore_1)
  );

  task automatic check_bit(input string tag, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, sample the Mealy output before the edge,
  // update the model at the edge, then compare registered outputs after it.
  task automatic step(input string tag, input logic rst_v, input logic d);
    sb_entry_t e;
    @(negedge clk);
    reset   = rst_v;
    data_in = d;
    e.exp_m1 = rst_v && d && (ones_cnt >= 2);
    if (!rst_v)  ones_cnt = 0;
    else if (d)  ones_cnt = (ones_cnt >= 3) ? 3 : ones_cnt + 1;
    else         ones_cnt = 0;
    e.exp_reg = (ones_cnt >= 3);
    e.obs_m1  = 1'b0;
    sb_q.push_back(e);
    #2;
    sb_q[sb_q.size()-1].obs_m1 = detect_mealy_1;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_bit({tag, "/mealy_1"}, e.obs_m1, e.exp_m1);
    check_bit({tag, "/mealy_2"}, detect_mealy_2, e.exp_reg);
    check_bit({tag, "/moore_1"}, detect_moore_1, e.exp_reg);
  endtask

  task automatic run_bits(input string tag, input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bits[i]);
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;
    step("reset", 1'b0, 1'b0);
    step("reset", 1'b0, 1'b1);
    step("reset", 1'b0, 1'b1);

    run_bits("three_ones", 32'b01110, 5);
    run_bits("six_ones",   32'b01111110, 8);
    run_bits("one_one_zero", 32'b110000, 6);
    run_bits("alternating", 32'b10101010, 8);
    run_bits("mixed", 32'b1101110110, 10);
    run_bits("flush", 32'b00, 2);

    run_bits("mid_reset_pre", 32'b11, 2);
    step("mid_reset_hold", 1'b0, 1'b1);
    step("mid_reset_hold", 1'b0, 1'b1);
    run_bits("mid_reset_post", 32'b11100, 5);

    // Mealy_1 follows data_in within a cycle while sitting in the two-ones state.
    run_bits("glitch_prep", 32'b11, 2);
    @(negedge clk);
    data_in = 1'b1;
    #1 check_bit("glitch_hi", detect_mealy_1, 1'b1);
    data_in = 1'b0;
    #1 check_bit("glitch_lo", detect_mealy_1, 1'b0);
    @(posedge clk);
    ones_cnt = 0;
    #1 check_bit("glitch_reg", detect_moore_1, 1'b0);
    run_bits("tail", 32'b000, 3);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
